bus_control_unit: RTL
=====================

Name: bus_control_unit

Overview:
- Timing and control sequencer that drives the common_bus datapath.
- Generates select, LD, INR, CLR, read and write from a 3-bit sequence counter (T0..T6), the instruction register and an indirect flag.
- Implements instruction fetch, decode, indirect addressing, LDA/STA/BUN/BSA/ISZ and the register-reference ops CLA/INC/HLT.
- Sits beside common_bus and is wired port-for-port to its control inputs.

Parameters:
- CLA_CODE, 16'h7800, register-reference clear-AC instruction word
- INC_CODE, 16'h7020, register-reference increment-AC instruction word
- HLT_CODE, 16'h7001, register-reference halt instruction word

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; leaves HALT and begins fetch at T0
- ir  in  16  current IR contents from the datapath
- dr_zero  in  1  datapath DR == 16'h0000
- select  out  3  bus source: 000 data_in, 001 AR, 010 PC, 011 DR, 100 AC, 101 IR, 110 TR, 111 memory
- LD  out  6  load from bus: [0] AR, [1] PC, [2] DR, [3] AC, [4] IR, [5] TR
- INR  out  5  increment: [0] AR, [1] PC, [2] DR, [3] AC, [4] TR
- CLR  out  5  clear, same indexing as INR
- read  out  1  memory read (only with select=111)
- write  out  1  memory write M[AR] <= bus
- halted  out  1  controller in HALT
- sc  out  3  current timing step, for debug

Behaviour:
- State: run/halt flag, sc[2:0], i_flag, op[2:0].
- Reset: async; HALT, sc=0, i_flag=0, op=0, halted=1. select, LD, INR, CLR, read and write are all 0 immediately, including mid-instruction.
- Outputs are Moore decodes of the registered state and ir. The only exception is INR[1] at ISZ T6, which equals dr_zero combinationally.
- HALT:
  - All control outputs are 0.
  - start=1 on an edge moves to run with sc=0.
  - start is ignored while running.
- T0: select=010, LD[0] (AR<=PC).
- T1: select=111, read=1, LD[4], INR[1] (IR<=M[AR], PC<=PC+1).
- T2: select=101, LD[0] (AR<=IR). Latch i_flag<=ir[15] and op<=ir[14:12].
- T3, op=7, i_flag=0 (register-reference):
  - ir==CLA_CODE: CLR[3].
  - ir==INC_CODE: INR[3].
  - ir==HLT_CODE: enter HALT at the edge.
  - In all cases sc<=0.
- T3, op!=7: if i_flag=1, select=111, read, LD[0] (AR<=M[AR]); otherwise no outputs. sc<=4.
- T4:
  - LDA(2): select=111, read, LD[2].
  - STA(3): select=100, write; sc<=0.
  - BUN(4): select=001, LD[1]; sc<=0.
  - BSA(5): select=010, write, INR[0].
  - ISZ(6): select=111, read, LD[2].
  - AND(0), ADD(1): no outputs; sc<=0.
- T5:
  - LDA: select=011, LD[3]; sc<=0.
  - BSA: select=001, LD[1]; sc<=0.
  - ISZ: INR[2].
- T6, ISZ only: select=011, write, INR[1]=dr_zero; sc<=0.
- At most one LD/write group is active per cycle. read and write are never asserted together.
- sc never exceeds 6. Any unreachable sc value returns to 0.
- Unsupported words (other op=7 codes, I/O with i_flag=1) execute as NOP and end at T3.

Optional Feature:
- Macro: BUS_CTRL_ILLEGAL_TRAP_EN.
- When defined: adds output illegal (1 bit, reset 0). An unsupported op=7 word at T3 sets illegal=1 and enters HALT. illegal clears on start.
- When undefined: no illegal port, and unsupported words are NOPs.

Decomposition:
- Shared package bus_ctrl_pkg:
  - select code constants
  - LD/INR/CLR bit-index constants
  - opcode constants (AND..ISZ, REGREF=7)
  - CLA/INC/HLT words
  - SC width
- One natural sub-module: bus_ctrl_seq_counter, a 3-bit counter with synchronous clr, inc and async reset.

Test Plan:
- Reset then start, ir=16'h2105 (LDA direct) -> T0 sel=010 LD=000001; T1 sel=111 read LD=010000 INR=00010; T2 sel=101 LD=000001; T4 sel=111 read LD=000100; T5 sel=011 LD=001000; then sc=0.
- ir=16'hB0F0 (STA indirect) -> T3 sel=111 read LD[0]; T4 sel=100 write=1; next sc=0.
- ir=16'h6010 (ISZ), dr_zero=1 at T6 -> T6 sel=011 write=1 INR=00010. With dr_zero=0 -> INR=00000.
- ir=16'h7001 -> halted=1 after T3; further edges produce all-zero outputs; a start pulse resumes at T0.
- ir=16'h5020 (BSA) -> T4 sel=010 write INR=00001; T5 sel=001 LD=000010.
- Assert reset during T4 of LDA -> outputs 0 the same timestep, halted=1, sc=0. With BUS_CTRL_ILLEGAL_TRAP_EN, ir=16'h7400 -> illegal=1, halted=1.

Source files
------------

// File: rtl/bus_ctrl_pkg.sv
// Shared constants for the common_bus control unit: bus source codes,
// register-control bit positions, opcodes, register-reference words and
// the run/halt state type.
package bus_ctrl_pkg;

    localparam int SC_W = 3;

    // Bus source select codes
    localparam logic [2:0] SEL_DATA = 3'd0;
    localparam logic [2:0] SEL_AR   = 3'd1;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_DR   = 3'd3;
    localparam logic [2:0] SEL_AC   = 3'd4;
    localparam logic [2:0] SEL_IR   = 3'd5;
    localparam logic [2:0] SEL_TR   = 3'd6;
    localparam logic [2:0] SEL_MEM  = 3'd7;

    // LD bit positions
    localparam int LD_AR = 0;
    localparam int LD_PC = 1;
    localparam int LD_DR = 2;
    localparam int LD_AC = 3;
    localparam int LD_IR = 4;
    localparam int LD_TR = 5;

    // INR / CLR bit positions
    localparam int RG_AR = 0;
    localparam int RG_PC = 1;
    localparam int RG_DR = 2;
    localparam int RG_AC = 3;
    localparam int RG_TR = 4;

    // Opcodes (ir[14:12])
    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_LDA    = 3'd2;
    localparam logic [2:0] OP_STA    = 3'd3;
    localparam logic [2:0] OP_BUN    = 3'd4;
    localparam logic [2:0] OP_BSA    = 3'd5;
    localparam logic [2:0] OP_ISZ    = 3'd6;
    localparam logic [2:0] OP_REGREF = 3'd7;

    // Register-reference instruction words
    localparam logic [15:0] CLA_WORD = 16'h7800;
    localparam logic [15:0] INC_WORD = 16'h7020;
    localparam logic [15:0] HLT_WORD = 16'h7001;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/bus_ctrl_seq_counter.sv
// Timing-step counter: synchronous clear has priority over increment,
// asynchronous active-high reset to zero.
module bus_ctrl_seq_counter
    import bus_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [SC_W-1:0] cnt_o
);

    logic [SC_W-1:0] cnt_q;
    logic [SC_W-1:0] cnt_d;

    // Next count: clear wins, otherwise optional increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_control_unit.sv
// Timing and control sequencer for the common_bus datapath. Decodes the
// run/halt state, the timing step, the latched indirect flag/opcode and the
// live IR into bus select, register load/increment/clear and memory strobes.
// Optional build macro BUS_CTRL_ILLEGAL_TRAP_EN adds an 'illegal' output that
// flags unsupported register-reference words and halts on them.
module bus_control_unit
    import bus_ctrl_pkg::*;
#(
    parameter logic [15:0] CLA_CODE = CLA_WORD,
    parameter logic [15:0] INC_CODE = INC_WORD,
    parameter logic [15:0] HLT_CODE = HLT_WORD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        dr_zero,
    output logic [2:0]  select,
    output logic [5:0]  LD,
    output logic [4:0]  INR,
    output logic [4:0]  CLR,
    output logic        read,
    output logic        write,
    output logic        halted,
`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [2:0]  sc
);

    run_state_e run_q, run_d;
    logic       i_flag_q, i_flag_d;
    logic [2:0] op_q, op_d;
    logic       sc_clr, sc_inc;
    logic       illegal_q, illegal_d;

    bus_ctrl_seq_counter u_sc (
        .clk_i (clock),
        .rst_i (reset),
        .clr_i (sc_clr),
        .inc_i (sc_inc),
        .cnt_o (sc)
    );

    // Next-state and Moore control decode; all outputs idle unless running
    always_comb begin
        run_d     = run_q;
        i_flag_d  = i_flag_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        sc_clr    = 1'b0;
        sc_inc    = 1'b0;
        select    = 3'b000;
        LD        = '0;
        INR       = '0;
        CLR       = '0;
        read      = 1'b0;
        write     = 1'b0;

        if (run_q == ST_HALT) begin
            sc_clr = 1'b1;
            if (start) begin
                run_d     = ST_RUN;
                illegal_d = 1'b0;
            end
        end else begin
            case (sc)
                3'd0: begin
                    select     = SEL_PC;
                    LD[LD_AR]  = 1'b1;
                    sc_inc     = 1'b1;
                end
                3'd1: begin
                    select     = SEL_MEM;
                    read       = 1'b1;
                    LD[LD_IR]  = 1'b1;
                    INR[RG_PC] = 1'b1;
                    sc_inc     = 1'b1;
                end
                3'd2: begin
                    select    = SEL_IR;
                    LD[LD_AR] = 1'b1;
                    i_flag_d  = ir[15];
                    op_d      = ir[14:12];
                    sc_inc    = 1'b1;
                end
                3'd3: begin
                    if (op_q == OP_REGREF) begin
                        // Register-reference or I/O words finish here
                        sc_clr = 1'b1;
                        if (!i_flag_q && ir == CLA_CODE) begin
                            CLR[RG_AC] = 1'b1;
                        end else if (!i_flag_q && ir == INC_CODE) begin
                            INR[RG_AC] = 1'b1;
                        end else if (!i_flag_q && ir == HLT_CODE) begin
                            run_d = ST_HALT;
                        end else begin
`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
                            illegal_d = 1'b1;
                            run_d     = ST_HALT;
`endif
                        end
                    end else begin
                        // Memory reference: fetch effective address if indirect
                        if (i_flag_q) begin
                            select    = SEL_MEM;
                            read      = 1'b1;
                            LD[LD_AR] = 1'b1;
                        end
                        sc_inc = 1'b1;
                    end
                end
                3'd4: begin
                    case (op_q)
                        OP_LDA, OP_ISZ: begin
                            select    = SEL_MEM;
                            read      = 1'b1;
                            LD[LD_DR] = 1'b1;
                            sc_inc    = 1'b1;
                        end
                        OP_STA: begin
                            select = SEL_AC;
                            write  = 1'b1;
                            sc_clr = 1'b1;
                        end
                        OP_BUN: begin
                            select    = SEL_AR;
                            LD[LD_PC] = 1'b1;
                            sc_clr    = 1'b1;
                        end
                        OP_BSA: begin
                            select     = SEL_PC;
                            write      = 1'b1;
                            INR[RG_AR] = 1'b1;
                            sc_inc     = 1'b1;
                        end
                        default: sc_clr = 1'b1;
                    endcase
                end
                3'd5: begin
                    case (op_q)
                        OP_LDA: begin
                            select    = SEL_DR;
                            LD[LD_AC] = 1'b1;
                            sc_clr    = 1'b1;
                        end
                        OP_BSA: begin
                            select    = SEL_AR;
                            LD[LD_PC] = 1'b1;
                            sc_clr    = 1'b1;
                        end
                        OP_ISZ: begin
                            INR[RG_DR] = 1'b1;
                            sc_inc     = 1'b1;
                        end
                        default: sc_clr = 1'b1;
                    endcase
                end
                3'd6: begin
                    // Write back incremented DR; skip next word when it wrapped to zero
                    if (op_q == OP_ISZ) begin
                        select     = SEL_DR;
                        write      = 1'b1;
                        INR[RG_PC] = dr_zero;
                    end
                    sc_clr = 1'b1;
                end
                default: sc_clr = 1'b1;
            endcase
        end
    end

    // Run/halt, latched instruction fields and trap flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q     <= ST_HALT;
            i_flag_q  <= 1'b0;
            op_q      <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            i_flag_q  <= i_flag_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    assign halted = (run_q == ST_HALT);

`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = &{1'b0, illegal_q, illegal_d};
`endif

endmodule
